// File: rtl/vga_pattern_sequencer.sv
// VGA test-pattern sequencer: picks one of four patterns,
// advancing only on frame boundaries, and emits one registered pixel per clock.
module vga_pattern_sequencer #(
    parameter int H_ACTIVE           = 640,
    parameter int V_ACTIVE           = 480,
    parameter int FRAMES_PER_PATTERN = 120
) (
    input  logic        vga_clk,
    input  logic        vga_rst,
    input  logic [9:0]  x_pos,
    input  logic [9:0]  y_pos,
    input  logic        btn_next,
    input  logic        auto_en,
    output logic [11:0] pixel_data,
    output logic [1:0]  pattern_id
);

    typedef enum logic [1:0] {
        PAT_GRAD  = 2'd0,
        PAT_BARS  = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_SOLID = 2'd3
    } pattern_e;

    localparam logic [9:0]  H_LIM      = 10'(H_ACTIVE);
    localparam logic [9:0]  V_LIM      = 10'(V_ACTIVE);
    localparam logic [9:0]  FPP_LAST   = 10'(FRAMES_PER_PATTERN - 1);
    localparam logic [11:0] SOLID_STEP = 12'h111;

    pattern_e    pattern_q, pattern_d;
    logic        pending_q, pending_d;
    logic [9:0]  frame_cnt_q, frame_cnt_d;
    logic [11:0] solid_q, solid_d;
    logic        prev_origin_q, prev_origin_d;
    logic [11:0] pixel_q, pixel_d;

    logic        origin;
    logic        frame_tick;
    logic        auto_expire;
    logic        advance;
    logic        blank;
    logic [2:0]  bar_idx;

    // Frame boundary detection and pattern/counter/solid-colour updates
    always_comb begin
        origin        = (x_pos == 10'd0) && (y_pos == 10'd0);
        frame_tick    = origin && !prev_origin_q;
        auto_expire   = auto_en && (frame_cnt_q == FPP_LAST);
        advance       = frame_tick && (pending_q || btn_next || auto_expire);
        prev_origin_d = origin;

        pattern_d = pattern_q;
        if (advance) begin
            pattern_d = pattern_e'(pattern_q + 2'd1);
        end

        // A tick always consumes any outstanding request, including one
        // arriving in the same cycle.
        pending_d = pending_q || btn_next;
        if (frame_tick) begin
            pending_d = 1'b0;
        end

        frame_cnt_d = frame_cnt_q;
        if (!auto_en || advance) begin
            frame_cnt_d = 10'd0;
        end else if (frame_tick) begin
            frame_cnt_d = frame_cnt_q + 10'd1;
        end

        solid_d = solid_q;
        if (frame_tick) begin
            solid_d = solid_q + SOLID_STEP;
        end
    end

    // Pixel generation, keyed on the pattern that is active after this edge
    always_comb begin
        blank   = (x_pos >= H_LIM) || (y_pos >= V_LIM);
        bar_idx = x_pos[9:7];
        pixel_d = 12'h000;
        unique case (pattern_d)
            PAT_GRAD:  pixel_d = {x_pos[8:5], y_pos[8:5], 4'h0};
            PAT_BARS:  pixel_d = {{4{bar_idx[2]}}, {4{bar_idx[1]}},
                                  {4{bar_idx[0]}}};
            PAT_CHECK: pixel_d = {12{x_pos[5] ^ y_pos[5]}};
            PAT_SOLID: pixel_d = solid_d;
            default:   pixel_d = 12'h000;
        endcase
        if (blank) begin
            pixel_d = 12'h000;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge vga_clk) begin
        if (vga_rst) begin
            pattern_q     <= PAT_GRAD;
            pending_q     <= 1'b0;
            frame_cnt_q   <= 10'd0;
            solid_q       <= 12'h000;
            prev_origin_q <= 1'b0;
            pixel_q       <= 12'h000;
        end else begin
            pattern_q     <= pattern_d;
            pending_q     <= pending_d;
            frame_cnt_q   <= frame_cnt_d;
            solid_q       <= solid_d;
            prev_origin_q <= prev_origin_d;
            pixel_q       <= pixel_d;
        end
    end

    assign pixel_data = pixel_q;
    assign pattern_id = pattern_q;

endmodule

// File: tb/tb_vga_pattern_sequencer.sv
// Bench for vga_pattern_sequencer: behavioural frame/pattern model,
// per-cycle compare, literal pins and randomized traffic.
module tb_vga_pattern_sequencer;

    localparam int FPP = 3;

    logic        vga_clk = 1'b0;
    logic        vga_rst = 1'b1;
    logic [9:0]  x_pos = '0;
    logic [9:0]  y_pos = '0;
    logic        btn_next = 1'b0;
    logic        auto_en = 1'b0;
    logic [11:0] pixel_data;
    logic [1:0]  pattern_id;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    int m_pat = 0;
    int m_pend = 0;
    int m_cnt = 0;
    int m_solid = 0;
    int m_prev = 0;
    int m_pix = 0;

    vga_pattern_sequencer #(
        .H_ACTIVE(640),
        .V_ACTIVE(480),
        .FRAMES_PER_PATTERN(FPP)
    ) dut (
        .vga_clk(vga_clk),
        .vga_rst(vga_rst),
        .x_pos(x_pos),
        .y_pos(y_pos),
        .btn_next(btn_next),
        .auto_en(auto_en),
        .pixel_data(pixel_data),
        .pattern_id(pattern_id)
    );

    always #5 vga_clk = ~vga_clk;

    function automatic int pix_of(input int pat, input int x,
                                  input int y, input int solid);
        int idx;
        if (x >= 640 || y >= 480) return 0;
        case (pat)
            0: return ((x / 32) % 16) * 256 + ((y / 32) % 16) * 16;
            1: begin
                idx = x / 128;
                return ((idx / 4) % 2) * 'hF00 + ((idx / 2) % 2) * 'h0F0
                     + (idx % 2) * 'h00F;
            end
            2: return (((x / 32) + (y / 32)) % 2 == 1) ? 'hFFF : 0;
            default: return solid;
        endcase
    endfunction

    task automatic model_step(input int x, input int y, input bit b,
                              input bit a, input bit r);
        bit org, tick, adv;
        org = (x == 0) && (y == 0);
        tick = org && (m_prev == 0);
        if (r) begin
            m_pat = 0; m_pend = 0; m_cnt = 0;
            m_solid = 0; m_prev = 0; m_pix = 0;
        end else begin
            adv = tick && (m_pend != 0 || b || (a && m_cnt == FPP - 1));
            if (adv) m_pat = (m_pat + 1) % 4;
            if (tick) m_pend = 0;
            else if (b) m_pend = 1;
            if (!a || adv) m_cnt = 0;
            else if (tick) m_cnt = m_cnt + 1;
            if (tick) m_solid = (m_solid + 'h111) % 4096;
            m_pix = pix_of(m_pat, x, y, m_solid);
            m_prev = org ? 1 : 0;
        end
    endtask

    task automatic cyc(input int x, input int y, input bit b,
                       input bit a, input bit r);
        @(negedge vga_clk);
        x_pos = 10'(x);
        y_pos = 10'(y);
        btn_next = b;
        auto_en = a;
        vga_rst = r;
        model_step(x, y, b, a, r);
    endtask

    task automatic settle();
        @(posedge vga_clk);
        #2;
    endtask

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Per-cycle comparison against the model
    always @(posedge vga_clk) begin
        #1;
        if (chk_en) begin
            checks++;
            if (int'(pixel_data) != m_pix || int'(pattern_id) != m_pat) begin
                failures++;
                $display("FAIL cycle t=%0t pix got=%h exp=%h pat got=%0d exp=%0d",
                         $time, pixel_data, m_pix[11:0], pattern_id, m_pat);
            end
        end
    end

    int pat_exp [6] = '{0, 0, 1, 1, 1, 2};

    initial begin
        cyc(5, 5, 0, 0, 1);
        chk_en = 1'b1;
        cyc(5, 5, 0, 0, 1);
        settle();
        check("rst_pix", int'(pixel_data), 0);
        check("rst_pat", int'(pattern_id), 0);

        for (int x = 0; x <= 650; x++) begin
            cyc(x, 0, 0, 0, 0);
            if (x == 100) begin
                settle();
                check("grad_x100", int'(pixel_data), 'h300);
            end
            if (x == 640) begin
                settle();
                check("blank_x640", int'(pixel_data), 'h000);
                check("line_pat", int'(pattern_id), 0);
            end
        end

        cyc(10, 5, 1, 0, 0);
        cyc(11, 5, 0, 0, 0);
        settle();
        check("pend_pat_hold", int'(pattern_id), 0);
        cyc(0, 0, 0, 0, 0);
        settle();
        check("tick_pat1", int'(pattern_id), 1);
        check("bars_origin", int'(pixel_data), 'h000);
        cyc(200, 10, 0, 0, 0);
        settle();
        check("bars_x200", int'(pixel_data), 'h00F);

        for (int k = 0; k < 3; k++) begin
            cyc(5, 5, 0, 0, 0);
            cyc(0, 0, 1, 0, 0);
        end
        settle();
        check("wrap_pat0", int'(pattern_id), 0);
        cyc(5, 5, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        settle();
        check("no_pend_after_wrap", int'(pattern_id), 0);

        cyc(5, 5, 0, 0, 1);
        cyc(5, 5, 0, 0, 1);
        for (int k = 0; k < 3; k++) begin
            cyc(5, 5, 1, 0, 0);
            cyc(0, 0, 0, 0, 0);
        end
        settle();
        check("solid_333", int'(pixel_data), 'h333);
        check("solid_pat", int'(pattern_id), 3);
        cyc(5, 5, 0, 0, 0);
        for (int k = 0; k < 4; k++) cyc(0, 0, 0, 0, 0);
        cyc(7, 7, 0, 0, 0);
        settle();
        check("hold_one_tick", int'(pixel_data), 'h444);

        cyc(5, 5, 0, 1, 1);
        for (int f = 0; f < 6; f++) begin
            cyc(0, 0, 0, 1, 0);
            settle();
            check($sformatf("auto_f%0d", f + 1), int'(pattern_id), pat_exp[f]);
            cyc(1 + f * 3, 2, 0, 1, 0);
            cyc(300, 200, 0, 1, 0);
        end
        for (int k = 0; k < 2; k++) begin
            cyc(0, 0, 0, 1, 0);
            cyc(9, 9, 0, 1, 0);
        end
        cyc(0, 0, 1, 1, 0);
        settle();
        check("auto_btn_single", int'(pattern_id), 3);

        cyc(5, 5, 0, 0, 1);
        for (int k = 0; k < 2; k++) begin
            cyc(5, 5, 1, 0, 0);
            cyc(0, 0, 0, 0, 0);
        end
        cyc(33, 33, 0, 0, 0);
        settle();
        check("check_pat", int'(pattern_id), 2);
        cyc(33, 33, 0, 0, 1);
        settle();
        check("midrst_pix", int'(pixel_data), 0);
        check("midrst_pat", int'(pattern_id), 0);
        cyc(33, 0, 0, 0, 0);
        settle();
        check("post_rst_pix", int'(pixel_data), 'h100);

        begin
            bit a;
            a = 1'b1;
            for (int n = 0; n < 4000; n++) begin
                int x, y;
                if ($urandom_range(0, 63) == 0) a = ~a;
                if ($urandom_range(0, 7) == 0) begin
                    x = 0; y = 0;
                end else begin
                    x = $urandom_range(0, 1023);
                    y = $urandom_range(0, 1023);
                end
                cyc(x, y, $urandom_range(0, 15) == 0, a,
                    $urandom_range(0, 499) == 0);
            end
        end
        settle();
        chk_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
